// File: rtl/forward_ctrl_if.sv
// rtl/forward_ctrl_if.sv - ID-stage request and EX-mux select bundle for forward_ctrl.
// stall_cnt_o and CNT_W exist only when FWD_STALL_CNT_EN is defined.
interface forward_ctrl_if #(
  parameter int REG_AW = 5
`ifdef FWD_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
);

  logic [REG_AW-1:0] rs1_i;
  logic [REG_AW-1:0] rs2_i;
  logic [REG_AW-1:0] rd_i;
  logic              regwrite_i;
  logic              memread_i;
  logic              flush_i;
  logic [1:0]        fwdA_o;
  logic [1:0]        fwdB_o;
  logic              stall_o;
`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt_o;
`endif

  // master: the decode stage side presenting instructions and consuming selects
  modport master (
    output rs1_i,
    output rs2_i,
    output rd_i,
    output regwrite_i,
    output memread_i,
    output flush_i,
    input  fwdA_o,
    input  fwdB_o,
`ifdef FWD_STALL_CNT_EN
    input  stall_cnt_o,
`endif
    input  stall_o
  );

  modport slave (
    input  rs1_i,
    input  rs2_i,
    input  rd_i,
    input  regwrite_i,
    input  memread_i,
    input  flush_i,
    output fwdA_o,
    output fwdB_o,
`ifdef FWD_STALL_CNT_EN
    output stall_cnt_o,
`endif
    output stall_o
  );

endinterface

// File: rtl/forward_ctrl.sv
// rtl/forward_ctrl.sv - 5-stage pipeline forwarding select and load-use stall controller.
// Optional stall cycle counter on stall_cnt_o when FWD_STALL_CNT_EN is defined.
module forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  forward_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("forward_ctrl: CNT_W must be at least 1");
  end

  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_regwrite;
  logic              idex_memread;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_regwrite;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_regwrite;

  logic              stall;
  logic              bubble;
  logic              exmem_live;
  logic              memwb_live;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  // A load in EX whose rd feeds the ID instruction cannot be forwarded in time.
  assign stall = idex_memread
               && (idex_rd != '0)
               && ((idex_rd == bus.rs1_i) || (idex_rd == bus.rs2_i))
               && !bus.flush_i;

  assign bubble = stall || bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_rs1       <= '0;
      idex_rs2       <= '0;
      idex_rd        <= '0;
      idex_regwrite  <= 1'b0;
      idex_memread   <= 1'b0;
      exmem_rd       <= '0;
      exmem_regwrite <= 1'b0;
      memwb_rd       <= '0;
      memwb_regwrite <= 1'b0;
    end else begin
      memwb_rd       <= exmem_rd;
      memwb_regwrite <= exmem_regwrite;
      exmem_rd       <= idex_rd;
      exmem_regwrite <= idex_regwrite;
      if (bubble) begin
        idex_rs1      <= '0;
        idex_rs2      <= '0;
        idex_rd       <= '0;
        idex_regwrite <= 1'b0;
        idex_memread  <= 1'b0;
      end else begin
        idex_rs1      <= bus.rs1_i;
        idex_rs2      <= bus.rs2_i;
        idex_rd       <= bus.rd_i;
        idex_regwrite <= bus.regwrite_i;
        idex_memread  <= bus.memread_i;
      end
    end
  end

  // x0 is hard-wired zero, so a write to it is never a forwarding source.
  assign exmem_live = exmem_regwrite && (exmem_rd != '0);
  assign memwb_live = memwb_regwrite && (memwb_rd != '0);

  always_comb begin
    fwd_a = SEL_RF;
    if (exmem_live && (exmem_rd == idex_rs1)) begin
      fwd_a = SEL_EXMEM;
    end else if (memwb_live && (memwb_rd == idex_rs1)) begin
      fwd_a = SEL_MEMWB;
    end
  end

  always_comb begin
    fwd_b = SEL_RF;
    if (exmem_live && (exmem_rd == idex_rs2)) begin
      fwd_b = SEL_EXMEM;
    end else if (memwb_live && (memwb_rd == idex_rs2)) begin
      fwd_b = SEL_MEMWB;
    end
  end

  assign bus.fwdA_o  = fwd_a;
  assign bus.fwdB_o  = fwd_b;
  assign bus.stall_o = stall;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// tb/tb_forward_ctrl.sv - scoreboard bench for forward_ctrl with directed pipeline sequences.
module tb_forward_ctrl;

  logic clk;
  logic rst;

  forward_ctrl_if bus ();

  forward_ctrl #(
    .REG_AW (5),
    .CNT_W  (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_cnt  = 0;

  task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
    end
  endtask

  // Outputs are combinational, so every cycle carries one expected entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.nm, "fwdA", {30'd0, bus.fwdA_o}, {30'd0, e.fa});
      cmp(e.nm, "fwdB", {30'd0, bus.fwdB_o}, {30'd0, e.fb});
      cmp(e.nm, "stall", {31'd0, bus.stall_o}, {31'd0, e.st});
`ifdef FWD_STALL_CNT_EN
      cmp(e.nm, "stall_cnt", bus.stall_cnt_o, e.cnt);
`endif
    end
  end

  task automatic step(input string nm, input logic r,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic rw, input logic mr, input logic fl,
                      input logic [1:0] efa, input logic [1:0] efb, input logic est);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.rs1_i      = s1;
    bus.rs2_i      = s2;
    bus.rd_i       = d;
    bus.regwrite_i = rw;
    bus.memread_i  = mr;
    bus.flush_i    = fl;
    e.nm  = nm;
    e.fa  = efa;
    e.fb  = efb;
    e.st  = est;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (r) exp_cnt = 0;
    else if (est) exp_cnt = exp_cnt + 1;
  endtask

  task automatic nop(input string nm, input logic [1:0] efa, input logic [1:0] efb);
    step(nm, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, efa, efb, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.rs1_i      = '0;
    bus.rs2_i      = '0;
    bus.rd_i       = '0;
    bus.regwrite_i = 1'b0;
    bus.memread_i  = 1'b0;
    bus.flush_i    = 1'b0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // distance 1: add x5 then sub x5,x7
    step("d1_add", 0, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, 0);
    step("d1_sub", 0, 5, 7, 9, 1, 0, 0, 2'b00, 2'b00, 0);
    nop("d1_ex", 2'b10, 2'b00);
    nop("d1_n1", 2'b00, 2'b00);
    nop("d1_n2", 2'b00, 2'b00);
    nop("d1_n3", 2'b00, 2'b00);

    // two writers of x6: EX/MEM wins
    step("p_w1", 0, 0, 0, 6, 1, 0, 0, 2'b00, 2'b00, 0);
    step("p_w2", 0, 0, 0, 6, 1, 0, 0, 2'b00, 2'b00, 0);
    step("p_use", 0, 6, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("p_ex", 2'b10, 2'b10);

    // distance 2 only
    step("d2_w", 0, 0, 0, 6, 1, 0, 0, 2'b00, 2'b00, 0);
    nop("d2_gap", 2'b00, 2'b00);
    step("d2_use", 0, 6, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("d2_ex", 2'b01, 2'b01);

    // distance 3 is left to the register file
    step("d3_w", 0, 0, 0, 6, 1, 0, 0, 2'b00, 2'b00, 0);
    nop("d3_g1", 2'b00, 2'b00);
    nop("d3_g2", 2'b00, 2'b00);
    step("d3_use", 0, 6, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("d3_ex", 2'b00, 2'b00);

    // load to x0 neither stalls nor forwards
    step("x0_lw", 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
    step("x0_use", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("x0_ex", 2'b00, 2'b00);
    nop("x0_n", 2'b00, 2'b00);

    // load-use on rs2
    step("lu_lw", 0, 0, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0);
    step("lu_add", 0, 3, 8, 10, 1, 0, 0, 2'b00, 2'b00, 1);
    step("lu_re", 0, 3, 8, 10, 1, 0, 0, 2'b00, 2'b00, 0);
    nop("lu_ex", 2'b00, 2'b01);

    // back-to-back loads, each with a dependent consumer
    step("bb_lw8", 0, 0, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0);
    step("bb_lw9", 0, 8, 0, 9, 1, 1, 0, 2'b00, 2'b00, 1);
    step("bb_lw9r", 0, 8, 0, 9, 1, 1, 0, 2'b00, 2'b00, 0);
    step("bb_add", 0, 9, 0, 11, 1, 0, 0, 2'b01, 2'b00, 1);
    step("bb_addr", 0, 9, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0);
    nop("bb_ex", 2'b01, 2'b00);

    // flush beats stall and leaves a bubble
    step("fl_lw", 0, 0, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0);
    step("fl_id", 0, 8, 0, 11, 1, 0, 1, 2'b00, 2'b00, 0);
    nop("fl_ex", 2'b00, 2'b00);

    // reset during a live distance-1 dependency
    step("rs_add", 0, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, 0);
    step("rs_sub", 0, 5, 7, 5, 1, 0, 0, 2'b00, 2'b00, 0);
    step("rs_hit", 1, 5, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
    step("rs_after", 0, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    nop("rs_tail", 2'b00, 2'b00);
    nop("rs_end", 2'b00, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
